// File: rtl/pc_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_unit_pkg
//  Purpose  : Shared vectors and next-pc selection for the DLX fetch PC unit
//  Revision : 1.0
// ============================================================================
package pc_unit_pkg;

    localparam logic [31:0] DLX_RESET_PC       = 32'h0000_0000;
    localparam logic [31:0] DLX_TRAP_PC        = 32'h0000_0008;
    localparam logic [31:0] QUICKSORT_RESET_PC = 32'h0000_1000;

    typedef enum logic [2:0] {
        SEL_RESET  = 3'd0,
        SEL_TRAP   = 3'd1,
        SEL_BRANCH = 3'd2,
        SEL_RET    = 3'd3,
        SEL_HOLD   = 3'd4,
        SEL_INC    = 3'd5
    } pc_sel_e;

    // Fixed redirect priority: reset > trap > branch > ret > stall > increment.
    function automatic pc_sel_e next_pc_sel(input logic reset, input logic trap,
                                            input logic branch, input logic ret,
                                            input logic stall);
        if (reset)       return SEL_RESET;
        else if (trap)   return SEL_TRAP;
        else if (branch) return SEL_BRANCH;
        else if (ret)    return SEL_RET;
        else if (stall)  return SEL_HOLD;
        else             return SEL_INC;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : pc_unit_if
//  Purpose  : Redirect/stall controls in, fetch address and RAS status out
//  Revision : 1.0
// ============================================================================
interface pc_unit_if #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
);
    localparam int c_cnt_w = $clog2(RAS_DEPTH) + 1;

    logic               stall;
    logic               branch;
    logic [WIDTH-1:0]   branch_pc;
    logic               call;
    logic [WIDTH-1:0]   link_pc;
    logic               ret;
    logic               trap;
    logic [WIDTH-1:0]   pc;
    logic [c_cnt_w-1:0] ras_count;
    logic               ras_overflow;

    modport master (
        output stall, branch, branch_pc, call, link_pc, ret, trap,
        input  pc, ras_count, ras_overflow
    );

    modport slave (
        input  stall, branch, branch_pc, call, link_pc, ret, trap,
        output pc, ras_count, ras_overflow
    );
endinterface
`default_nettype wire

// File: rtl/pc_unit_ras_stack.sv
`default_nettype none
// ============================================================================
//  Module   : ras_stack
//  Purpose  : Circular return-address stack; overwrites oldest entry when full
//  Revision : 1.0
// ============================================================================
module ras_stack #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  wire logic                           clk,
    input  wire logic                           reset,
    input  wire logic                           push,
    input  wire logic                           pop,
    input  wire logic [WIDTH-1:0]               wdata,
    output logic      [WIDTH-1:0]               top,
    output logic      [$clog2(RAS_DEPTH):0]     count,
    output logic                                overflow
);
    localparam int c_ptr_w = $clog2(RAS_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(RAS_DEPTH);

    logic [WIDTH-1:0]   r_mem [RAS_DEPTH];
    logic [c_ptr_w-1:0] r_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_overflow;

    // Pointer names the next free slot; when full it coincides with the oldest.
    always_ff @(negedge clk) begin
        if (push && !reset) begin
            r_mem[r_ptr] <= wdata;
        end
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            r_ptr      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= 1'b0;
            if (push) begin
                r_ptr <= r_ptr + 1'b1;
                if (r_count == c_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end else if (pop && (r_count != '0)) begin
                r_ptr   <= r_ptr - 1'b1;
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign top      = r_mem[r_ptr - 1'b1];
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_unit
//  Purpose  : DLX fetch program counter with prioritised redirects and RAS
//  Revision : 1.0
// ============================================================================
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(DLX_RESET_PC),
    parameter logic [WIDTH-1:0] TRAP_PC   = WIDTH'(DLX_TRAP_PC),
    parameter int               INC       = 4,
    parameter int               RAS_DEPTH = 4
) (
    input  wire logic  clk,
    input  wire logic  reset,
    pc_unit_if.slave   bus
);
    localparam int c_cnt_w = $clog2(RAS_DEPTH) + 1;

    logic [WIDTH-1:0]   r_pc;
    logic [WIDTH-1:0]   w_next_pc;
    logic [WIDTH-1:0]   w_ras_top;
    logic [c_cnt_w-1:0] w_ras_count;
    logic               w_ras_overflow;
    logic               w_push;
    logic               w_pop;
    pc_sel_e            w_sel;

    // Stack side effects only happen when their redirect is the winner.
    assign w_push = bus.branch && bus.call && !bus.trap;
    assign w_pop  = bus.ret && !bus.branch && !bus.trap;

    ras_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .reset    (reset),
        .push     (w_push),
        .pop      (w_pop),
        .wdata    (bus.link_pc),
        .top      (w_ras_top),
        .count    (w_ras_count),
        .overflow (w_ras_overflow)
    );

    always_comb begin
        w_sel     = next_pc_sel(reset, bus.trap, bus.branch, bus.ret, bus.stall);
        w_next_pc = r_pc + WIDTH'(INC);
        case (w_sel)
            SEL_RESET:  w_next_pc = RESET_PC;
            SEL_TRAP:   w_next_pc = TRAP_PC;
            SEL_BRANCH: w_next_pc = bus.branch_pc;
            SEL_RET:    w_next_pc = (w_ras_count != '0) ? w_ras_top : bus.branch_pc;
            SEL_HOLD:   w_next_pc = r_pc;
            default:    w_next_pc = r_pc + WIDTH'(INC);
        endcase
    end

    // Negedge update keeps the address stable for the posedge SRAM read.
    always_ff @(negedge clk) begin
        r_pc <= w_next_pc;
    end

    assign bus.pc           = r_pc;
    assign bus.ras_count    = w_ras_count;
    assign bus.ras_overflow = w_ras_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_unit
//  Purpose  : Directed self-checking bench for pc_unit (quicksort reset vector)
//  Revision : 1.0
// ============================================================================
module tb_pc_unit;
    import pc_unit_pkg::*;

    localparam int c_width = 32;
    localparam int c_depth = 4;

    logic clk;
    logic reset;
    int   n_asserts;
    int   n_fails;

    pc_unit_if #(.WIDTH(c_width), .RAS_DEPTH(c_depth)) bus ();

    pc_unit #(
        .WIDTH     (c_width),
        .RESET_PC  (QUICKSORT_RESET_PC),
        .TRAP_PC   (32'h0000_0008),
        .INC       (4),
        .RAS_DEPTH (c_depth)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.stall = 0; bus.branch = 0; bus.call = 0; bus.ret = 0; bus.trap = 0;
    endtask

    task automatic push(input logic [31:0] target, input logic [31:0] link);
        idle();
        bus.branch = 1; bus.call = 1; bus.branch_pc = target; bus.link_pc = link;
        tick();
    endtask

    initial begin
        n_asserts = 0;
        n_fails   = 0;
        idle();
        bus.branch_pc = '0;
        bus.link_pc   = '0;

        // Reset vector and sequential fetch
        reset = 1;
        tick();
        check("reset_pc", bus.pc, 32'h1000);
        check("reset_count", 32'(bus.ras_count), 0);
        check("reset_ovf", 32'(bus.ras_overflow), 0);
        reset = 0;
        tick(); check("seq1", bus.pc, 32'h1004);
        tick(); check("seq2", bus.pc, 32'h1008);
        tick(); check("seq3", bus.pc, 32'h100C);
        check("seq_count", 32'(bus.ras_count), 0);

        // Priority: trap beats branch beats stall
        bus.branch = 1; bus.branch_pc = 32'h20;
        tick(); check("branch_to_20", bus.pc, 32'h20);
        bus.trap = 1; bus.branch_pc = 32'h400; bus.stall = 1;
        tick(); check("prio_trap", bus.pc, 32'h08);
        bus.trap = 0;
        tick(); check("prio_branch_over_stall", bus.pc, 32'h400);
        bus.branch = 0;
        tick(); check("stall_hold", bus.pc, 32'h400);
        idle();

        // Call / return
        push(32'h100, 32'h24);
        check("call_pc", bus.pc, 32'h100);
        check("call_count", 32'(bus.ras_count), 1);
        idle();
        tick(); check("after_call_seq", bus.pc, 32'h104);
        bus.call = 1;
        tick(); check("call_no_branch_pc", bus.pc, 32'h108);
        check("call_no_branch_count", 32'(bus.ras_count), 1);
        idle(); bus.ret = 1; bus.branch_pc = 32'hDEAD;
        tick(); check("ret_pc", bus.pc, 32'h24);
        check("ret_count", 32'(bus.ras_count), 0);

        // Empty return falls back to branch_pc
        bus.branch_pc = 32'h300;
        tick(); check("empty_ret_pc", bus.pc, 32'h300);
        check("empty_ret_count", 32'(bus.ras_count), 0);

        // Overflow on fifth push only
        for (int i = 1; i <= 5; i++) begin
            push(32'h500, 32'(i * 16));
            check($sformatf("push%0d_ovf", i), 32'(bus.ras_overflow), (i == 5) ? 1 : 0);
            check($sformatf("push%0d_count", i), 32'(bus.ras_count), (i >= 4) ? 4 : i);
        end
        idle(); bus.ret = 1; bus.branch_pc = 32'h600;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("pop%0d_pc", i), bus.pc, 32'(32'h50 - i * 16));
            check($sformatf("pop%0d_count", i), 32'(bus.ras_count), 3 - i);
            check($sformatf("pop%0d_ovf", i), 32'(bus.ras_overflow), 0);
        end
        tick(); check("pop_empty_pc", bus.pc, 32'h600);
        check("pop_empty_count", 32'(bus.ras_count), 0);

        // ret with branch is ignored; stall does not block a ret
        push(32'h10, 32'h70);
        idle(); bus.ret = 1; bus.branch = 1; bus.branch_pc = 32'h700;
        tick(); check("ret_branch_pc", bus.pc, 32'h700);
        check("ret_branch_count", 32'(bus.ras_count), 1);
        idle(); bus.ret = 1; bus.stall = 1;
        tick(); check("stall_ret_pc", bus.pc, 32'h70);
        check("stall_ret_count", 32'(bus.ras_count), 0);

        // trap suppresses a push and leaves contents intact
        push(32'h10, 32'h80);
        bus.trap = 1; bus.link_pc = 32'h90;
        tick(); check("trap_call_pc", bus.pc, 32'h08);
        check("trap_call_count", 32'(bus.ras_count), 1);
        idle(); bus.ret = 1;
        tick(); check("ret_after_trap", bus.pc, 32'h80);

        // Address wrap
        idle(); bus.branch = 1; bus.branch_pc = 32'hFFFF_FFFC;
        tick(); check("wrap_setup", bus.pc, 32'hFFFF_FFFC);
        idle();
        tick(); check("wrap_pc", bus.pc, 32'h0);

        // Reset aborts a same-edge pop
        push(32'h10, 32'hA0);
        push(32'h20, 32'hB0);
        check("two_count", 32'(bus.ras_count), 2);
        idle(); bus.ret = 1; reset = 1;
        tick(); check("mid_reset_pc", bus.pc, 32'h1000);
        check("mid_reset_count", 32'(bus.ras_count), 0);
        check("mid_reset_ovf", 32'(bus.ras_overflow), 0);
        reset = 0; bus.branch_pc = 32'h900;
        tick(); check("post_reset_ret", bus.pc, 32'h900);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_unit.md
# pc_unit

Parametrised fetch program-counter unit for the pipelined DLX core, replacing the fixed 32-bit PC register. It generates the fetch address for instruction SRAM each cycle and honours trap, branch and stall redirects with fixed priority. It adds a configurable reset/trap vector and a circular return-address stack (RAS) so that `jr r31` returns can redirect without waiting on the register file. It sits between the ID-stage control (redirect/stall sources) and the instruction memory address port.

## Interface
Parameters:
- WIDTH, 32: address width in bits.
- RESET_PC, 0: value loaded into `pc` on reset. Set to 32'h00001000 for quicksort images.
- TRAP_PC, 32'h00000008: redirect target on `trap`.
- INC, 4: sequential increment in bytes.
- RAS_DEPTH, 4: number of RAS entries. Must be a power of two, ≥2.

Ports:
- clk  in  1  Pipeline clock. All state updates on the **negedge**, so the address is stable for the posedge SRAM read.
- reset  in  1  Synchronous, active-high. Sampled at the updating edge.
- stall  in  1  Hold the current `pc` (ID-stage kill/stall).
- branch  in  1  Redirect to `branch_pc`.
- branch_pc  in  WIDTH  Branch/jump target. Also the fallback target for `ret` when the RAS is empty.
- call  in  1  Qualifies `branch` as jump-and-link: push `link_pc`.
- link_pc  in  WIDTH  Return address to push.
- ret  in  1  Return redirect: pop the RAS and jump to the popped top.
- trap  in  1  Redirect to TRAP_PC.
- pc  out  WIDTH  Current fetch address.
- ras_count  out  $clog2(RAS_DEPTH)+1  Number of valid entries.
- ras_overflow  out  1  One-cycle pulse: a push overwrote the oldest entry.

## Operation
- Next-`pc` priority, evaluated each negedge:
  1. reset → RESET_PC
  2. trap → TRAP_PC
  3. branch → branch_pc
  4. ret → RAS top if ras_count>0, else branch_pc
  5. stall → pc (hold)
  6. otherwise → pc+INC, modulo 2^WIDTH (wraps silently)
- RAS effects apply only when the corresponding redirect is the winning action:
  - Push when branch&call&!trap.
  - Pop when ret won, i.e. ret&!branch&!trap.
  - call without branch: ignored.
  - ret when branch is also high: ignored, no pop.
- Push writes `link_pc` at the top pointer, increments the pointer modulo RAS_DEPTH, and increments ras_count, saturating at RAS_DEPTH.
  - Push while full: overwrites the oldest entry and pulses ras_overflow.
- Pop decrements the pointer and ras_count.
  - Pop while empty: pointer and count unchanged.
- stall never blocks a redirect or its RAS effect, since redirects outrank stall.
- trap leaves RAS contents unchanged.
- Reset: pc=RESET_PC, pointer=0, ras_count=0, ras_overflow=0. Entry contents are don't-care.
  - Reset asserted mid-operation aborts any same-edge push/pop.

## Timing
- One-cycle latency: inputs sampled at negedge N produce the new `pc` right after negedge N and hold it until negedge N+1.
- The RAS top read for ret is combinational from the current stack state, so ret redirects in the same edge that it pops.
- ras_count and ras_overflow update on the same edge as `pc`. ras_overflow is high for exactly one cycle per overflowing push.
- There is no back-to-back restriction: a push at edge N followed by a ret at edge N+1 returns the just-pushed link_pc.

## Structure
- Shared package: DLX_RESET_PC and DLX_TRAP_PC defaults, plus a per-image reset-vector constant, so no filename comparisons appear in RTL.
- One sub-module, `ras_stack`:
  - Parameters: WIDTH, RAS_DEPTH.
  - Ports: push, pop, wdata, top, count, overflow.
- `pc_unit` holds the priority mux and the pc register.

## Test plan
- **Reset vector:** RESET_PC=32'h1000, reset high one edge, then idle 3 cycles → pc=1000, 1004, 1008, 100C; ras_count=0.
- **Priority:** at pc=0x20, assert trap, branch (branch_pc=0x400) and stall together → pc=0x08. Next edge, branch and stall only → pc=0x400.
- **Call/return:** branch&call with branch_pc=0x100, link_pc=0x24 → pc=0x100, count=1. Later ret with branch_pc=0xDEAD → pc=0x24, count=0.
- **Empty ret fallback:** count=0, ret with branch_pc=0x300 → pc=0x300, count stays 0.
- **Overflow (RAS_DEPTH=4):** push links 0x10, 0x20, 0x30, 0x40, 0x50 → ras_overflow pulses on the 5th push only, count=4. Four rets → pc=0x50, 0x40, 0x30, 0x20. A fifth ret falls back to branch_pc.
- **Wrap and reset mid-stack:** pc=0xFFFFFFFC idle → pc=0. With count=2, reset together with ret → pc=RESET_PC, count=0, no overflow pulse.
